// File: rtl/led_pulse_driver.sv
// LED blink driver: turns single-cycle event pulses into fixed-length LED blinks.
// Requests arriving mid-blink are queued in a saturating counter and replayed back-to-back.
module led_pulse_driver #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 4,
  parameter int unsigned MAX_PEND   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  output logic       led,
  output logic       busy,
  output logic [7:0] pend,
  output logic       ovf
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } state_e;

  localparam logic [15:0] OnReload  = 16'(ON_CYCLES - 1);
  localparam logic [15:0] OffReload = 16'(OFF_CYCLES - 1);
  localparam logic [7:0]  MaxPend   = 8'(MAX_PEND);

  state_e      state_q;
  logic [15:0] timer_q;
  logic [7:0]  pend_q;
  logic [7:0]  pend_d;
  logic        led_q;
  logic        ovf_q;

  logic timer_done;
  logic have_pend;
  logic blink_start;
  logic full;
  logic accept;
  logic drop;

  always_comb begin
    timer_done  = (timer_q == 16'd0);
    have_pend   = (pend_q != 8'd0);
    blink_start = have_pend && ((state_q == StIdle) || ((state_q == StOff) && timer_done));
    full        = (pend_q == MaxPend);
    // A dequeue in the same cycle frees a slot, so a trig at full is still accepted.
    accept      = trig && !(full && !blink_start);
    drop        = trig && full && !blink_start;
    pend_d      = pend_q;
    if (accept && !blink_start) begin
      pend_d = pend_q + 8'd1;
    end else if (!accept && blink_start) begin
      pend_d = pend_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      timer_q <= 16'd0;
      pend_q  <= 8'd0;
      led_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= drop;
      case (state_q)
        StIdle: begin
          if (blink_start) begin
            state_q <= StOn;
            timer_q <= OnReload;
            led_q   <= 1'b1;
          end
        end
        StOn: begin
          if (timer_done) begin
            state_q <= StOff;
            timer_q <= OffReload;
            led_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StOff: begin
          if (timer_done) begin
            if (have_pend) begin
              state_q <= StOn;
              timer_q <= OnReload;
              led_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: begin
          // Unreachable encoding: park in idle, leave queue and timer alone.
          state_q <= StIdle;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign led  = led_q;
  assign ovf  = ovf_q;
  assign pend = pend_q;
  assign busy = (state_q != StIdle) || have_pend;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Self-checking bench for led_pulse_driver: two instances (4/4/7 and 1/1/3) checked every
// cycle against a blink-position reference model, plus directed corner cases.
module tb_led_pulse_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic       led_a, busy_a, ovf_a;
  logic       led_b, busy_b, ovf_b;
  logic [7:0] pend_a, pend_b;

  led_pulse_driver #(.ON_CYCLES(4), .OFF_CYCLES(4), .MAX_PEND(7)) dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .led(led_a), .busy(busy_a), .pend(pend_a), .ovf(ovf_a)
  );

  led_pulse_driver #(.ON_CYCLES(1), .OFF_CYCLES(1), .MAX_PEND(3)) dut_b (
    .clk(clk), .rst(rst), .trig(trig_b), .led(led_b), .busy(busy_b), .pend(pend_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: a blink is a window of ON+OFF cycles; m_pos is the index within it.
  int p_on[2];
  int p_off[2];
  int p_max[2];
  int m_pend[2];
  int m_pos[2];
  bit m_act[2];
  int m_acc[2];
  int m_drop[2];

  int   rises_a, rises_b, ovfs_a, pend_max_a;
  logic prev_led_a, prev_led_b;
  int   rise_cyc[$];

  task automatic check(input string tag, input logic [15:0] obs, input int exp);
    checks++;
    assert (obs === 16'(exp)) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit will_start(input int i);
    return (m_pend[i] > 0) && (!m_act[i] || m_pos[i] == p_on[i] + p_off[i] - 1);
  endfunction

  function automatic bit model_busy(input int i);
    return m_act[i] || (m_pend[i] > 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_pos[i] = 0; m_act[i] = 1'b0; m_acc[i] = 0; m_drop[i] = 0;
    end
    rises_a = 0; rises_b = 0; ovfs_a = 0; pend_max_a = 0;
    prev_led_a = 1'b0; prev_led_b = 1'b0;
  endtask

  bit m_ovf[2];

  task automatic model_edge(input int i, input bit t);
    bit start;
    bit acc;
    start = will_start(i);
    acc = t && ((m_pend[i] < p_max[i]) || start);
    m_ovf[i] = t && !acc;
    if (acc) m_acc[i]++;
    if (m_ovf[i]) m_drop[i]++;
    if (start) begin
      m_act[i] = 1'b1;
      m_pos[i] = 0;
    end else if (m_act[i]) begin
      if (m_pos[i] == p_on[i] + p_off[i] - 1) m_act[i] = 1'b0;
      else m_pos[i]++;
    end
    m_pend[i] = m_pend[i] + int'(acc) - int'(start);
  endtask

  task automatic check_all();
    check("a.led",  led_a,  int'(m_act[0] && m_pos[0] < p_on[0]));
    check("a.busy", busy_a, int'(model_busy(0)));
    check("a.pend", pend_a, m_pend[0]);
    check("a.ovf",  ovf_a,  int'(m_ovf[0]));
    check("b.led",  led_b,  int'(m_act[1] && m_pos[1] < p_on[1]));
    check("b.busy", busy_b, int'(model_busy(1)));
    check("b.pend", pend_b, m_pend[1]);
    check("b.ovf",  ovf_b,  int'(m_ovf[1]));
    if (led_a === 1'b1 && prev_led_a === 1'b0) begin
      rises_a++;
      rise_cyc.push_back(cyc);
    end
    if (led_b === 1'b1 && prev_led_b === 1'b0) rises_b++;
    if (ovf_a === 1'b1) ovfs_a++;
    if (int'(pend_a) > pend_max_a) pend_max_a = int'(pend_a);
    prev_led_a = led_a;
    prev_led_b = led_b;
  endtask

  // Called at a falling edge: drive trigs, take one rising edge, check at the next fall.
  task automatic step(input bit t_a, input bit t_b);
    trig_a = t_a;
    trig_b = t_b;
    @(posedge clk);
    cyc++;
    model_edge(0, t_a);
    model_edge(1, t_b);
    @(negedge clk);
    trig_a = 1'b0;
    trig_b = 1'b0;
    check_all();
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (!model_busy(0) && !model_busy(1)) break;
      step(1'b0, 1'b0);
    end
    check("drain.a.busy", busy_a, 0);
    check("drain.b.busy", busy_b, 0);
    check("drain.a.blinks", 16'(rises_a), m_acc[0]);
    check("drain.b.blinks", 16'(rises_b), m_acc[1]);
  endtask

  int t0;

  initial begin
    p_on  = '{4, 1};
    p_off = '{4, 1};
    p_max = '{7, 3};
    m_ovf = '{1'b0, 1'b0};
    model_reset();

    // Reset state
    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // ON=OFF=1 corner on B: two trigs give led 1,0,1,0 then idle
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("corner.led0", led_b, 1);
    step(1'b0, 1'b0);
    check("corner.led1", led_b, 0);
    step(1'b0, 1'b0);
    check("corner.led2", led_b, 1);
    step(1'b0, 1'b0);
    check("corner.led3", led_b, 0);
    step(1'b0, 1'b0);
    check("corner.idle", busy_b, 0);
    drain();

    // Single request on A
    step(1'b1, 1'b0);
    check("single.pend", pend_a, 1);
    step(1'b0, 1'b0);
    check("single.led", led_a, 1);
    drain();

    // Burst: trigs at relative edges 0, 2, 3 -> rises at 1, 9, 17, peak pend 2
    rise_cyc.delete();
    pend_max_a = 0;
    t0 = cyc + 1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    drain();
    check("burst.nblinks", 16'(rise_cyc.size()), 3);
    if (rise_cyc.size() == 3) begin
      check("burst.rise0", 16'(rise_cyc[0] - t0), 1);
      check("burst.rise1", 16'(rise_cyc[1] - t0), 9);
      check("burst.rise2", 16'(rise_cyc[2] - t0), 17);
    end
    check("burst.peak", 16'(pend_max_a), 2);

    // Saturation: 10 consecutive trigs from idle
    model_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    check("sat.pend", pend_a, 7);
    check("sat.ovfs", 16'(ovfs_a), m_drop[0]);

    // Trig coinciding with a dequeue while full: no drop, pend holds
    for (int n = 0; n < 20; n++) begin
      if (will_start(0)) break;
      step(1'b0, 1'b0);
    end
    check("simul.pre.pend", pend_a, 7);
    step(1'b1, 1'b0);
    check("simul.pend", pend_a, 7);
    check("simul.ovf", ovf_a, 0);
    drain();

    // Async reset mid-ON with pend=3
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    check("rstmid.pre.led", led_a, 1);
    check("rstmid.pre.pend", pend_a, 3);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid.led", led_a, 0);
    check("rstmid.busy", busy_a, 0);
    check("rstmid.pend", pend_a, 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    check("rstmid.noblink", 16'(rises_a), 0);

    // Random traffic on both instances
    model_reset();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    check("rand.a.ovfs", 16'(ovfs_a), m_drop[0]);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
